// File: rtl/mips_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_uart_rx : 16x-oversampled 8N1 (8E1 with MIPS_UART_RX_PARITY_EN)       |
// |                serial receiver feeding the MIPS debug unit ready/data pair |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mips_uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 326,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_rx,
  input  logic                 i_rx_reset,
  output logic                 o_rx_ready,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_overrun,
  output logic                 o_rx_parity_err
);

  localparam int C_BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int C_S_W    = $clog2(OVERSAMPLE);
  localparam int C_N_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [C_BAUD_W-1:0] C_BAUD_LAST = C_BAUD_W'(BAUD_DIV - 1);
  localparam logic [C_S_W-1:0]    C_S_HALF    = C_S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [C_S_W-1:0]    C_S_LAST    = C_S_W'(OVERSAMPLE - 1);
  localparam logic [C_N_W-1:0]    C_N_LAST    = C_N_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef MIPS_UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rx_s;
  logic [C_BAUD_W-1:0]  r_baud_cnt;
  logic                 w_tick;
  logic                 r_armed;

  state_t               r_state;
  state_t               w_state_nx;
  logic [C_S_W-1:0]     r_s;
  logic [C_S_W-1:0]     w_s_nx;
  logic [C_N_W-1:0]     r_n;
  logic [C_N_W-1:0]     w_n_nx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nx;

  logic                 w_start;
  logic                 w_done_ok;
  logic                 w_frame_bad;
`ifdef MIPS_UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 w_par_bad_nx;
  logic                 w_par_flag;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_baud_cnt <= '0;
    end else if (r_baud_cnt == C_BAUD_LAST) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  assign w_tick = (r_baud_cnt == C_BAUD_LAST);

  // Dropping armed on a frame error keeps a stuck-low line from retriggering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (w_rx_s) begin
      r_armed <= 1'b1;
    end else if (w_start || w_frame_bad) begin
      r_armed <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_shift <= w_shift_nx;
    end
  end

`ifdef MIPS_UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par_bad <= 1'b0;
    end else begin
      r_par_bad <= w_par_bad_nx;
    end
  end
`endif

  always_comb begin
    w_state_nx   = r_state;
    w_s_nx       = r_s;
    w_n_nx       = r_n;
    w_shift_nx   = r_shift;
    w_start      = 1'b0;
    w_done_ok    = 1'b0;
    w_frame_bad  = 1'b0;
`ifdef MIPS_UART_RX_PARITY_EN
    w_par_bad_nx = r_par_bad;
    w_par_flag   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_start    = 1'b1;
          w_s_nx     = '0;
          w_state_nx = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_s == C_S_HALF) begin
            if (!w_rx_s) begin
              w_s_nx     = '0;
              w_n_nx     = '0;
              w_state_nx = ST_DATA;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_s == C_S_LAST) begin
            w_s_nx     = '0;
            w_shift_nx = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_n == C_N_LAST) begin
`ifdef MIPS_UART_RX_PARITY_EN
              w_state_nx = ST_PARITY;
`else
              w_state_nx = ST_STOP;
`endif
            end else begin
              w_n_nx = r_n + 1'b1;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
`ifdef MIPS_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          if (r_s == C_S_LAST) begin
            w_s_nx       = '0;
            w_par_bad_nx = w_rx_s ^ (^r_shift);
            w_state_nx   = ST_STOP;
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_s == C_S_LAST) begin
            w_state_nx = ST_IDLE;
            if (!w_rx_s) begin
              w_frame_bad = 1'b1;
            end
`ifdef MIPS_UART_RX_PARITY_EN
            else if (r_par_bad) begin
              w_par_flag = 1'b1;
            end
`endif
            else begin
              w_done_ok = 1'b1;
            end
          end else begin
            w_s_nx = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Clear is applied first so a completion on the same edge takes priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rx_ready     <= 1'b0;
      o_rx_data      <= '0;
      o_rx_frame_err <= 1'b0;
      o_rx_overrun   <= 1'b0;
    end else begin
      if (i_rx_reset) begin
        o_rx_ready     <= 1'b0;
        o_rx_frame_err <= 1'b0;
        o_rx_overrun   <= 1'b0;
      end
      if (w_done_ok) begin
        o_rx_data  <= r_shift;
        o_rx_ready <= 1'b1;
        if (o_rx_ready) begin
          o_rx_overrun <= 1'b1;
        end
      end
      if (w_frame_bad) begin
        o_rx_frame_err <= 1'b1;
      end
    end
  end

`ifdef MIPS_UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_rx_parity_err <= 1'b0;
    end else if (w_par_flag) begin
      o_rx_parity_err <= 1'b1;
    end else if (i_rx_reset) begin
      o_rx_parity_err <= 1'b0;
    end
  end
`else
  assign o_rx_parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_uart_rx.sv
`default_nettype none
// tb_mips_uart_rx : directed self-checking bench for mips_uart_rx
// (BAUD_DIV=4, OVERSAMPLE=16, so one bit lasts 64 clk).
module tb_mips_uart_rx;

  localparam int C_BIT = 64;

  logic       clk;
  logic       reset;
  logic       r_rx;
  logic       r_rx_clr;
  logic       w_ready;
  logic [7:0] w_data;
  logic       w_ferr;
  logic       w_ovr;
  logic       w_perr;

  int n_checks = 0;
  int n_errors = 0;

  mips_uart_rx #(
    .DATA_BITS  (8),
    .BAUD_DIV   (4),
    .OVERSAMPLE (16)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .i_rx            (r_rx),
    .i_rx_reset      (r_rx_clr),
    .o_rx_ready      (w_ready),
    .o_rx_data       (w_data),
    .o_rx_frame_err  (w_ferr),
    .o_rx_overrun    (w_ovr),
    .o_rx_parity_err (w_perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic hold_line(input logic v, input int cycles);
    r_rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  // Full frame; par_good only matters when the parity bit is present.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_good);
    hold_line(1'b0, C_BIT);
    for (int i = 0; i < 8; i++) hold_line(d[i], C_BIT);
`ifdef MIPS_UART_RX_PARITY_EN
    hold_line(par_good ? ^d : ~^d, C_BIT);
`endif
    hold_line(stop_v, C_BIT);
    r_rx = 1'b1;
  endtask

  task automatic pulse_clear();
    r_rx_clr = 1'b1;
    @(negedge clk);
    r_rx_clr = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    r_rx     = 1'b1;
    r_rx_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", w_ready, 0);
    check("rst_data",  w_data,  0);
    check("rst_ferr",  w_ferr,  0);
    check("rst_ovr",   w_ovr,   0);
    check("rst_perr",  w_perr,  0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Scenario 1: clean byte, then clear.
    send_frame(8'h72, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s1_ready", w_ready, 1);
    check("s1_data",  w_data,  8'h72);
    check("s1_ferr",  w_ferr,  0);
    check("s1_ovr",   w_ovr,   0);
    check("s1_perr",  w_perr,  0);
    pulse_clear();
    check("s1_clr_ready", w_ready, 0);
    check("s1_clr_data",  w_data,  8'h72);

    // Scenario 2: 12-clk glitch must be rejected.
    hold_line(1'b0, 12);
    hold_line(1'b1, 100);
    check("s2_glitch_ready", w_ready, 0);
    send_frame(8'h73, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s2_ready", w_ready, 1);
    check("s2_data",  w_data,  8'h73);
    pulse_clear();

    // Scenario 3: framing error followed by a long low line.
    send_frame(8'h6C, 1'b0, 1'b1);
    hold_line(1'b0, 200);
    check("s3_ferr",  w_ferr,  1);
    check("s3_ready", w_ready, 0);
    check("s3_data",  w_data,  8'h73);
    hold_line(1'b1, C_BIT);
    send_frame(8'h6E, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s3_ready2", w_ready, 1);
    check("s3_data2",  w_data,  8'h6E);
    pulse_clear();
    check("s3_clr_ferr", w_ferr, 0);

    // Scenario 4: overrun.
    send_frame(8'h6C, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s4_data1", w_data, 8'h6C);
    check("s4_ovr1",  w_ovr,  0);
    send_frame(8'h6E, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s4_data2",  w_data,  8'h6E);
    check("s4_ready2", w_ready, 1);
    check("s4_ovr2",   w_ovr,   1);
    pulse_clear();
    check("s4_clr_ready", w_ready, 0);
    check("s4_clr_ovr",   w_ovr,   0);

    // Scenario 5: asynchronous reset in the middle of bit 4 of 0xA5.
    hold_line(1'b0, C_BIT);
    for (int i = 0; i < 4; i++) hold_line(((8'hA5 >> i) & 8'h01) != 0, C_BIT);
    hold_line(1'b0, C_BIT / 2);
    #3 reset = 1'b1;
    #1;
    check("s5_async_data",  w_data,  0);
    check("s5_async_ready", w_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    hold_line(1'b1, 2 * C_BIT);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s5_data",  w_data,  8'hFF);
    check("s5_ready", w_ready, 1);
    check("s5_perr",  w_perr,  0);
    pulse_clear();

`ifdef MIPS_UART_RX_PARITY_EN
    // Scenario 6: parity error, then good parity.
    send_frame(8'h73, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check("s6_perr",  w_perr,  1);
    check("s6_ready", w_ready, 0);
    check("s6_data0", w_data,  8'hFF);
    send_frame(8'h73, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check("s6_ready2", w_ready, 1);
    check("s6_data2",  w_data,  8'h73);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_uart_rx.md
# mips_uart_rx

Serial receiver that feeds the MIPS debug unit. It deserialises 8N1 (optionally 8E1) frames from the host UART line using a 16x oversampled baud tick. It presents each byte on a ready/data pair, and the debug unit clears that pair with a level-sensitive clear input. The block sits between the board RX pin and the debug unit's `i_uart_rx_ready` / `i_uart_rx_data` / `o_uart_rx_reset` ports.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame, sent LSB first.
- `BAUD_DIV`, 326: clk cycles per oversample tick; 326 gives 16 × 9600 baud at 50 MHz. Must be ≥ 2.
- `OVERSAMPLE`, 16: ticks per bit period. Must be even.

Ports:
- `clk`  in  1: the single clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-high; returns all state to reset values.
- `i_rx`  in  1: asynchronous serial line; idles high.
- `i_rx_reset`  in  1: level clear from the debug unit.
- `o_rx_ready`  out  1: a byte is held in `o_rx_data`.
- `o_rx_data`  out  `DATA_BITS`: the last valid byte.
- `o_rx_frame_err`  out  1: sticky; stop bit sampled low.
- `o_rx_overrun`  out  1: sticky; a byte completed while `o_rx_ready` was already 1.
- `o_rx_parity_err`  out  1: sticky; parity mismatch. Constant 0 unless the macro is defined.

## Operation
- Reset values:
  - all outputs 0;
  - synchroniser flops 1;
  - tick counter 0;
  - FSM in IDLE;
  - `armed` flag 0.
- Input path: `i_rx` passes through a 2-flop synchroniser; only the synchronised value `rx_s` is used.
- Tick generator: free-running counter 0..`BAUD_DIV`-1. It pulses `tick` for one cycle when count == `BAUD_DIV`-1, then wraps to 0.
- `armed` flag:
  - set when `rx_s` == 1;
  - cleared on a start bit.
- FSM states:
  - IDLE: when `armed` and `rx_s` == 0, clear the tick count `s` and go to START.
  - START: on each tick, s++. When s == `OVERSAMPLE`/2-1 (7 by default):
    - if `rx_s` == 0: s := 0, bit count n := 0, go to DATA;
    - else the start was a glitch: go to IDLE.
  - DATA: on each tick, s++. When s == `OVERSAMPLE`-1: s := 0, shift register := {`rx_s`, shift[`DATA_BITS`-1:1]}, n++. After `DATA_BITS` bits, go to STOP (or PARITY when enabled).
  - PARITY (macro only): sample after `OVERSAMPLE` ticks, compare with even parity of the shift register, go to STOP.
  - STOP: sample after `OVERSAMPLE` ticks, then go to IDLE.
    - Sample 1, no parity error: `o_rx_data` := shift, `o_rx_ready` := 1. If `o_rx_ready` was already 1, also `o_rx_overrun` := 1.
    - Sample 0: `o_rx_frame_err` := 1; data and ready unchanged.
    - Parity error: `o_rx_parity_err` := 1; data and ready unchanged.
- Clear: at any edge where `i_rx_reset` == 1, clear `o_rx_ready`, `o_rx_frame_err`, `o_rx_overrun` and `o_rx_parity_err`. `o_rx_data` holds its value.
- Simultaneous completion and clear: the completion wins. Ready = 1 and data = new byte; error flags from that completion are set, and the other flags clear.
- Break or line stuck low: after a frame error the FSM stays in IDLE until `armed` is set again. No phantom frames are received.

## Timing
- Synchroniser latency: 2 cycles from `i_rx` to `rx_s`.
- Each sample is taken at mid-bit: start is confirmed at `OVERSAMPLE`/2 ticks, then every `OVERSAMPLE` ticks after that.
- `o_rx_ready` rises one cycle after the stop-bit sample tick. That is about (1 + `DATA_BITS` + 0.5) × `OVERSAMPLE` × `BAUD_DIV` cycles after the start edge, ±`BAUD_DIV` cycles of tick phase, plus 2 cycles.
- Clear latency: 1 edge. Ready is low on the cycle after `i_rx_reset` is sampled high.
- Reset mid-frame: the frame is discarded immediately and asynchronously. Reception resumes once the line is seen high.

## Configuration
- `MIPS_UART_RX_PARITY_EN` defined:
  - adds the PARITY state, one even-parity bit between the data bits and the stop bit;
  - the frame is 8E1;
  - `o_rx_parity_err` is live.
- Not defined:
  - 8N1 frames, no PARITY state;
  - `o_rx_parity_err` is tied to 0.

## Test plan
All scenarios use `BAUD_DIV`=4 and `OVERSAMPLE`=16, so one bit is 64 clk.
- Scenario 1: send 0x72 as 8N1 → `o_rx_ready`=1, `o_rx_data`=0x72, all error flags 0. Then pulse `i_rx_reset` for 1 cycle → ready=0 on the next edge, data still 0x72.
- Scenario 2: drive `i_rx` low for 12 clk, then high; then send 0x73 → no ready from the glitch; ready=1 with data=0x73 after the frame.
- Scenario 3: send 0x6C with stop bit 0, hold the line low 200 clk, release it, then send 0x6E → after the first frame, `o_rx_frame_err`=1, ready=0 and data unchanged; after release, data=0x6E and ready=1.
- Scenario 4: send 0x6C then 0x6E with no clear in between → data=0x6E, ready=1, `o_rx_overrun`=1. Then `i_rx_reset` → ready=0 and overrun=0.
- Scenario 5: assert `reset` during bit 4 of 0xA5 → all outputs 0 immediately. Then send 0xFF → data=0xFF, ready=1.
- Scenario 6 (`MIPS_UART_RX_PARITY_EN`): send 0x73 with parity bit 0 (expected 1) → `o_rx_parity_err`=1, ready=0. Then send 0x73 with parity bit 1 → ready=1, data=0x73.
